// File: rtl/turret_bullet_launcher_pkg.sv
// Shared constants and types for the turret bullet launcher.
// Angle one-hot bit order: 90,60,45,30,0,330,315,300,270 degrees.
package turret_pkg;

    localparam int ANGLE_90_BIT  = 0;
    localparam int ANGLE_60_BIT  = 1;
    localparam int ANGLE_45_BIT  = 2;
    localparam int ANGLE_30_BIT  = 3;
    localparam int ANGLE_0_BIT   = 4;
    localparam int ANGLE_330_BIT = 5;
    localparam int ANGLE_315_BIT = 6;
    localparam int ANGLE_300_BIT = 7;
    localparam int ANGLE_270_BIT = 8;

    localparam logic [8:0] ANGLE_0 = 9'(1) << ANGLE_0_BIT;

    localparam logic [7:0] FIRE_KEY = 8'h2C;

    localparam int SPEED          = 2;
    localparam int MAX_AMMO       = 3;
    localparam int RELOAD_FRAMES  = 60;
    localparam int EXPLODE_FRAMES = 8;
    localparam int AMMO_W         = $clog2(MAX_AMMO + 1);

    localparam logic signed [11:0] X_MIN = 12'sd0;
    localparam logic signed [11:0] X_MAX = 12'sd639;
    localparam logic signed [11:0] Y_MIN = 12'sd0;
    localparam logic signed [11:0] Y_MAX = 12'sd479;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        FLIGHT  = 2'd2,
        EXPLODE = 2'd3
    } launcher_state_e;

    function automatic logic in_range(input logic signed [11:0] v,
                                      input logic signed [11:0] lo,
                                      input logic signed [11:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/turret_bullet_launcher_ammo_counter.sv
// Magazine counter: spends one round per launch and refills one round
// every RELOAD_FRAMES frames while not full.
module bullet_ammo_counter
    import turret_pkg::*;
(
    input  logic              clk2,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              consume,
    output logic [AMMO_W-1:0] ammo,
    output logic              empty
);

    localparam int                RELOAD_W    = $clog2(RELOAD_FRAMES);
    localparam logic [RELOAD_W-1:0] RELOAD_LAST = RELOAD_W'(RELOAD_FRAMES - 1);
    localparam logic [AMMO_W-1:0] AMMO_FULL   = AMMO_W'(MAX_AMMO);

    logic [AMMO_W-1:0]   ammo_q, ammo_d;
    logic [RELOAD_W-1:0] reload_cnt_q, reload_cnt_d;
    logic                not_full, reload, take;

    // A launch and a reload landing together cancel out; the counter still restarts.
    always_comb begin
        not_full     = (ammo_q != AMMO_FULL);
        reload       = not_full && frame_tick && (reload_cnt_q == RELOAD_LAST);
        take         = consume && (ammo_q != '0);
        reload_cnt_d = reload_cnt_q;
        ammo_d       = ammo_q;
        if (!not_full || reload) begin
            reload_cnt_d = '0;
        end else if (frame_tick) begin
            reload_cnt_d = reload_cnt_q + RELOAD_W'(1);
        end
        if (take && !reload) begin
            ammo_d = ammo_q - AMMO_W'(1);
        end else if (reload && !take) begin
            ammo_d = ammo_q + AMMO_W'(1);
        end
    end

    always_ff @(posedge clk2) begin
        if (!Reset) begin
            ammo_q       <= AMMO_FULL;
            reload_cnt_q <= '0;
        end else begin
            ammo_q       <= ammo_d;
            reload_cnt_q <= reload_cnt_d;
        end
    end

    assign ammo  = ammo_q;
    assign empty = (ammo_q == '0);

endmodule

// File: rtl/turret_bullet_launcher.sv
// Turns a fire keypress into a single projectile: launch, per-frame flight,
// screen-edge detection and a timed explosion, gated by the ammo counter.
module turret_bullet_launcher
    import turret_pkg::*;
(
    input  logic              clk2,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic [7:0]        keycode,
    input  logic [8:0]        angle_onehot,
    input  logic [9:0]        motion_x,
    input  logic [9:0]        motion_y,
    input  logic [9:0]        turret_x,
    input  logic [9:0]        turret_y,
    output logic              bullet_active,
    output logic              bullet_exploding,
    output logic [9:0]        bullet_x,
    output logic [9:0]        bullet_y,
    output logic [8:0]        bullet_angle,
    output logic [AMMO_W-1:0] ammo,
    output logic              fire_reject
);

    localparam int                  EXPL_W    = $clog2(EXPLODE_FRAMES);
    localparam logic [EXPL_W-1:0]   EXPL_LAST = EXPL_W'(EXPLODE_FRAMES - 1);
    localparam logic signed [11:0]  SPEED_S   = 12'(SPEED);

    launcher_state_e   state_q, state_d;
    logic              key_q, key_d;
    logic              active_q, active_d;
    logic              exploding_q, exploding_d;
    logic              reject_q, reject_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [9:0]        vx_q, vx_d, vy_q, vy_d;
    logic [8:0]        angle_q, angle_d;
    logic [EXPL_W-1:0] expl_cnt_q, expl_cnt_d;
    logic              fire_hit, press, consume, ammo_empty;
    logic signed [11:0] vx_ext, vy_ext, nx, ny;

    bullet_ammo_counter u_ammo (
        .clk2       (clk2),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .consume    (consume),
        .ammo       (ammo),
        .empty      (ammo_empty)
    );

    // Next-position math is 12-bit signed so an off-screen step never wraps back on.
    always_comb begin
        fire_hit    = (keycode == FIRE_KEY);
        press       = fire_hit && !key_q;
        key_d       = fire_hit;
        vx_ext      = {{2{vx_q[9]}}, vx_q};
        vy_ext      = {{2{vy_q[9]}}, vy_q};
        nx          = $signed({2'b00, x_q}) + vx_ext * SPEED_S;
        ny          = $signed({2'b00, y_q}) + vy_ext * SPEED_S;
        state_d     = state_q;
        active_d    = active_q;
        exploding_d = exploding_q;
        reject_d    = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        angle_d     = angle_q;
        expl_cnt_d  = expl_cnt_q;
        consume     = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    if (!ammo_empty && $onehot(angle_onehot)) begin
                        state_d = LAUNCH;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                angle_d  = angle_onehot;
                vx_d     = motion_x;
                vy_d     = motion_y;
                x_d      = turret_x;
                y_d      = turret_y;
                consume  = 1'b1;
                active_d = 1'b1;
                state_d  = FLIGHT;
            end
            FLIGHT: begin
                if (frame_tick) begin
                    if (in_range(nx, X_MIN, X_MAX) && in_range(ny, Y_MIN, Y_MAX)) begin
                        x_d = nx[9:0];
                        y_d = ny[9:0];
                    end else begin
                        active_d    = 1'b0;
                        exploding_d = 1'b1;
                        expl_cnt_d  = '0;
                        state_d     = EXPLODE;
                    end
                end
            end
            EXPLODE: begin
                if (frame_tick) begin
                    if (expl_cnt_q == EXPL_LAST) begin
                        exploding_d = 1'b0;
                        expl_cnt_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        expl_cnt_d = expl_cnt_q + EXPL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (!Reset) begin
            state_q     <= IDLE;
            key_q       <= 1'b0;
            active_q    <= 1'b0;
            exploding_q <= 1'b0;
            reject_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            vx_q        <= '0;
            vy_q        <= '0;
            angle_q     <= ANGLE_0;
            expl_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            active_q    <= active_d;
            exploding_q <= exploding_d;
            reject_q    <= reject_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            angle_q     <= angle_d;
            expl_cnt_q  <= expl_cnt_d;
        end
    end

    assign bullet_active    = active_q;
    assign bullet_exploding = exploding_q;
    assign bullet_x         = x_q;
    assign bullet_y         = y_q;
    assign bullet_angle     = angle_q;
    assign fire_reject      = reject_q;

endmodule
